// File: rtl/usb_reg_pkg.sv
// Shared definitions for the USB register responder: FSM state encoding and
// default parameter values used by usb_reg_responder.
package usb_reg_pkg;

   localparam int DEF_ADDR_WIDTH     = 8;
   localparam int DEF_BYTECNT_SIZE   = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPEN,
      ST_WR,
      ST_RD_REQ,
      ST_RD_DRIVE
   } usb_reg_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous control bit; both flops reset
// to RESET_VAL so the synchronized output starts at the line's idle level.
module cdc_sync_bit #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_usb,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: clocked state always uses non-blocking assignments so every flop
   // samples pre-edge values; blocking here would collapse the two stages.
   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_reg_responder.sv
// Bridges an asynchronous host strobe bus (cen/rdn/wrn) onto a synchronous
// register interface. Optional idle watchdog: define USB_REG_TIMEOUT_EN.
module usb_reg_responder
   import usb_reg_pkg::*;
#(
   parameter int pADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int pBYTECNT_SIZE   = DEF_BYTECNT_SIZE,
   parameter int pTIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk_usb,
   input  logic                     reset_n,
   input  logic [pADDR_WIDTH-1:0]   usb_addr,
   input  logic [7:0]               usb_din,
   output logic [7:0]               usb_dout,
   output logic                     usb_data_oe,
   input  logic                     usb_rdn,
   input  logic                     usb_wrn,
   input  logic                     usb_cen,
   output logic [pADDR_WIDTH-1:0]   reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic [7:0]               reg_datao,
   input  logic [7:0]               reg_datai,
   output logic                     reg_write,
   output logic                     reg_read,
   output logic                     reg_addrvalid,
   output logic                     timeout_err
);

   usb_reg_state_e state;

   logic cen_s, wrn_s, rdn_s;
   logic cen_d, wrn_d, rdn_d;
   logic wr_rise, rd_fall, cen_fall;
   logic addr_diff, strobe_evt, tmo_hit;

   cdc_sync_bit #(.RESET_VAL(1'b1)) u_sync_cen (
      .clk_usb (clk_usb),
      .reset_n (reset_n),
      .d       (usb_cen),
      .q       (cen_s)
   );

   cdc_sync_bit #(.RESET_VAL(1'b1)) u_sync_wrn (
      .clk_usb (clk_usb),
      .reset_n (reset_n),
      .d       (usb_wrn),
      .q       (wrn_s)
   );

   cdc_sync_bit #(.RESET_VAL(1'b1)) u_sync_rdn (
      .clk_usb (clk_usb),
      .reset_n (reset_n),
      .d       (usb_rdn),
      .q       (rdn_s)
   );

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         cen_d <= 1'b1;
         wrn_d <= 1'b1;
         rdn_d <= 1'b1;
      end else begin
         cen_d <= cen_s;
         wrn_d <= wrn_s;
         rdn_d <= rdn_s;
      end
   end

   // Each edge only counts while the other strobe is idle, so rdn and wrn
   // low together never issue anything and the FSM simply holds.
   assign wr_rise    = wrn_s & ~wrn_d & rdn_s;
   assign rd_fall    = ~rdn_s & rdn_d & wrn_s;
   assign cen_fall   = ~cen_s & cen_d;
   assign strobe_evt = wr_rise | rd_fall;
   assign addr_diff  = (usb_addr != reg_address);

`ifdef USB_REG_TIMEOUT_EN
   localparam int CNT_W = $clog2(pTIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] idle_cnt;
   logic             tmo_flag;

   assign tmo_hit     = (state == ST_OPEN) && !cen_s && !strobe_evt && wrn_s && rdn_s &&
                        (idle_cnt == CNT_W'(pTIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_flag;

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state != ST_OPEN || cen_s || strobe_evt || !wrn_s || !rdn_s || tmo_hit)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + CNT_W'(1);

         if (cen_fall)
            tmo_flag <= 1'b0;
         else if (tmo_hit)
            tmo_flag <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk_usb or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         usb_dout      <= '0;
         usb_data_oe   <= 1'b0;
         reg_address   <= '0;
         reg_bytecnt   <= '0;
         reg_datao     <= '0;
         reg_write     <= 1'b0;
         reg_read      <= 1'b0;
         reg_addrvalid <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         reg_read  <= 1'b0;

         if (cen_s || tmo_hit) begin
            state         <= ST_IDLE;
            usb_data_oe   <= 1'b0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
         end else begin
            case (state)
               // After a watchdog trip, a fresh cen falling edge is needed to reopen.
               ST_IDLE: begin
                  if (!timeout_err || cen_fall) begin
                     state         <= ST_OPEN;
                     reg_address   <= usb_addr;
                     reg_bytecnt   <= '0;
                     reg_addrvalid <= 1'b1;
                  end
               end

               ST_OPEN: begin
                  if (strobe_evt && addr_diff) begin
                     reg_address <= usb_addr;
                     reg_bytecnt <= '0;
                  end
                  if (wr_rise) begin
                     reg_datao <= usb_din;
                     reg_write <= 1'b1;
                     state     <= ST_WR;
                  end else if (rd_fall) begin
                     reg_read <= 1'b1;
                     state    <= ST_RD_REQ;
                  end
               end

               ST_WR: begin
                  reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
                  state       <= ST_OPEN;
               end

               // A host pulse short enough to end before data is driven skips RD_DRIVE.
               ST_RD_REQ: begin
                  usb_dout <= reg_datai;
                  if (rdn_s) begin
                     reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
                     state       <= ST_OPEN;
                  end else begin
                     usb_data_oe <= 1'b1;
                     state       <= ST_RD_DRIVE;
                  end
               end

               ST_RD_DRIVE: begin
                  if (rdn_s) begin
                     usb_data_oe <= 1'b0;
                     reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
                     state       <= ST_OPEN;
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_reg_responder.sv
// Scoreboard bench for usb_reg_responder: expected register writes and host
// read data are queued as stimulus is driven and retired as the DUT responds.
module tb_usb_reg_responder;

   localparam int AW = 8;
   localparam int BW = 7;

   logic          clk_usb = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] usb_addr = '0;
   logic [7:0]    usb_din = '0;
   logic [7:0]    usb_dout;
   logic          usb_data_oe;
   logic          usb_rdn = 1'b1;
   logic          usb_wrn = 1'b1;
   logic          usb_cen = 1'b1;
   logic [AW-1:0] reg_address;
   logic [BW-1:0] reg_bytecnt;
   logic [7:0]    reg_datao;
   logic [7:0]    reg_datai;
   logic          reg_write;
   logic          reg_read;
   logic          reg_addrvalid;
   logic          timeout_err;

   logic          use_cnt = 1'b0;
   logic [7:0]    datai_v = '0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic [BW-1:0] cnt;
   } wr_exp_t;

   wr_exp_t    wr_q[$];
   logic [7:0] rd_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_wr = 0;
   int n_rd = 0;
   logic wr_prev = 1'b0;
   logic rd_prev = 1'b0;

   always #5 clk_usb = ~clk_usb;

   assign reg_datai = use_cnt ? 8'(reg_bytecnt) : datai_v;

   usb_reg_responder #(
      .pADDR_WIDTH     (AW),
      .pBYTECNT_SIZE   (BW),
      .pTIMEOUT_CYCLES (1023)
   ) dut (
      .clk_usb       (clk_usb),
      .reset_n       (reset_n),
      .usb_addr      (usb_addr),
      .usb_din       (usb_din),
      .usb_dout      (usb_dout),
      .usb_data_oe   (usb_data_oe),
      .usb_rdn       (usb_rdn),
      .usb_wrn       (usb_wrn),
      .usb_cen       (usb_cen),
      .reg_address   (reg_address),
      .reg_bytecnt   (reg_bytecnt),
      .reg_datao     (reg_datao),
      .reg_datai     (reg_datai),
      .reg_write     (reg_write),
      .reg_read      (reg_read),
      .reg_addrvalid (reg_addrvalid),
      .timeout_err   (timeout_err)
   );

   // Write monitor: every reg_write pulse retires one queued expectation.
   always @(negedge clk_usb) begin
      wr_exp_t e;
      wr_exp_t got;
      if (reg_write) begin
         n_wr++;
         n_checks++;
         got = '{addr: reg_address, data: reg_datao, cnt: reg_bytecnt};
         if (wr_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr_unexpected got addr=%h data=%h cnt=%0d expected no write",
                     reg_address, reg_datao, reg_bytecnt);
         end else begin
            e = wr_q.pop_front();
            if (got !== e) begin
               n_errors++;
               $display("FAIL wr_match got addr=%h data=%h cnt=%0d expected addr=%h data=%h cnt=%0d",
                        got.addr, got.data, got.cnt, e.addr, e.data, e.cnt);
            end
         end
         if (wr_prev) begin
            n_errors++;
            $display("FAIL wr_pulse_width got 2+ cycles expected 1");
         end
      end
      if (reg_read) begin
         n_rd++;
         if (rd_prev) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_pulse_width got 2+ cycles expected 1");
         end
      end
      wr_prev = reg_write;
      rd_prev = reg_read;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_usb);
      #1;
   endtask

   task automatic host_open(input logic [AW-1:0] addr);
      usb_addr = addr;
      usb_cen  = 1'b0;
      wait_cycles(5);
   endtask

   task automatic host_close();
      usb_cen = 1'b1;
      wait_cycles(5);
   endtask

   task automatic host_write(input logic [AW-1:0] addr, input logic [7:0] data,
                             input logic [BW-1:0] cnt);
      wr_q.push_back('{addr: addr, data: data, cnt: cnt});
      usb_addr = addr;
      usb_din  = data;
      usb_wrn  = 1'b0;
      wait_cycles(3);
      usb_wrn  = 1'b1;
      wait_cycles(6);
   endtask

   task automatic host_read(input logic [AW-1:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      rd_q.push_back(exp);
      usb_addr = addr;
      usb_rdn  = 1'b0;
      for (int i = 0; i < 20 && !usb_data_oe; i++) @(negedge clk_usb);
      e = rd_q.pop_front();
      n_checks++;
      if (usb_data_oe !== 1'b1) begin
         n_errors++;
         $display("FAIL rd_oe_rise got oe=%b expected 1", usb_data_oe);
      end
      n_checks++;
      if (usb_dout !== e) begin
         n_errors++;
         $display("FAIL rd_data got %h expected %h", usb_dout, e);
      end
      usb_rdn = 1'b1;
      for (int i = 0; i < 10 && usb_data_oe; i++) @(negedge clk_usb);
      n_checks++;
      if (usb_data_oe !== 1'b0) begin
         n_errors++;
         $display("FAIL rd_oe_fall got oe=%b expected 0", usb_data_oe);
      end
      wait_cycles(3);
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({usb_dout, usb_data_oe, reg_address, reg_bytecnt, reg_datao,
           reg_write, reg_read, reg_addrvalid, timeout_err} !== '0) begin
         n_errors++;
         $display("FAIL %s got dout=%h oe=%b addr=%h cnt=%0d datao=%h wr=%b rd=%b av=%b to=%b expected all 0",
                  name, usb_dout, usb_data_oe, reg_address, reg_bytecnt, reg_datao,
                  reg_write, reg_read, reg_addrvalid, timeout_err);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_cycles(3);
      check_all_zero("reset_state");
      #2 reset_n = 1'b1;
      wait_cycles(3);
      check_bit("reset_idle_av", reg_addrvalid, 1'b0);
   endtask

   task automatic test_write_single();
      int w0 = n_wr;
      host_open(8'h04);
      check_bit("open_av", reg_addrvalid, 1'b1);
      host_write(8'h04, 8'hA5, 7'd0);
      check_int("single_wr_pulses", n_wr - w0, 1);
      host_close();
      check_bit("close_av", reg_addrvalid, 1'b0);
   endtask

   task automatic test_read_single();
      int r0 = n_rd;
      datai_v = 8'hA5;
      host_open(8'h04);
      host_read(8'h04, 8'hA5);
      check_int("single_rd_pulses", n_rd - r0, 1);
      host_close();
   endtask

   task automatic test_burst_write();
      logic [7:0] d[4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
      host_open(8'h11);
      for (int i = 0; i < 4; i++) host_write(8'h11, d[i], BW'(i));
      host_close();
      check_int("burst_cnt_after_close", int'(reg_bytecnt), 0);
   endtask

   task automatic test_read_burst();
      int r0 = n_rd;
      use_cnt = 1'b1;
      host_open(8'h03);
      for (int i = 0; i < 90; i++) host_read(8'h03, 8'(i));
      check_int("rd_burst_pulses", n_rd - r0, 90);
      host_close();
      use_cnt = 1'b0;
   endtask

   task automatic test_addr_change();
      host_open(8'h20);
      host_write(8'h20, 8'h01, 7'd0);
      host_write(8'h20, 8'h02, 7'd1);
      host_write(8'h30, 8'h03, 7'd0);
      host_write(8'h30, 8'h04, 7'd1);
      host_close();
   endtask

   task automatic test_protocol_violation();
      int w0 = n_wr;
      int r0 = n_rd;
      host_open(8'h44);
      usb_wrn = 1'b0;
      wait_cycles(4);
      usb_rdn = 1'b0;
      wait_cycles(4);
      usb_wrn = 1'b1;
      wait_cycles(4);
      usb_rdn = 1'b1;
      wait_cycles(4);
      check_int("viol_no_strobe", (n_wr - w0) + (n_rd - r0), 0);
      check_bit("viol_oe", usb_data_oe, 1'b0);
      host_write(8'h44, 8'h77, 7'd0);
      host_close();
   endtask

   task automatic test_cen_high_ignore();
      int w0 = n_wr;
      int r0 = n_rd;
      for (int i = 0; i < 3; i++) begin
         usb_wrn = 1'b0;
         wait_cycles(4);
         usb_wrn = 1'b1;
         wait_cycles(4);
         usb_rdn = 1'b0;
         wait_cycles(4);
         usb_rdn = 1'b1;
         wait_cycles(4);
      end
      check_int("cen_high_no_strobe", (n_wr - w0) + (n_rd - r0), 0);
      check_bit("cen_high_av", reg_addrvalid, 1'b0);
   endtask

   task automatic test_wrap();
      host_open(8'h40);
      for (int i = 0; i < 130; i++) host_write(8'h40, 8'(i ^ 8'h3C), BW'(i));
      host_close();
   endtask

   task automatic test_reset_mid_burst();
      host_open(8'h50);
      host_write(8'h50, 8'hAA, 7'd0);
      host_write(8'h50, 8'hBB, 7'd1);
      @(posedge clk_usb);
      #3 reset_n = 1'b0;
      #1 check_all_zero("mid_burst_reset");
      usb_cen = 1'b1;
      usb_wrn = 1'b1;
      usb_rdn = 1'b1;
      wait_cycles(2);
      #2 reset_n = 1'b1;
      wait_cycles(2);
      host_open(8'h50);
      host_write(8'h50, 8'hCC, 7'd0);
      host_close();
   endtask

   task automatic test_timeout();
      host_open(8'h60);
      wait_cycles(1100);
`ifdef USB_REG_TIMEOUT_EN
      check_int("tmo_flag_av", int'({timeout_err, reg_addrvalid}), 2);
      usb_cen = 1'b1;
      wait_cycles(5);
      check_bit("tmo_sticky", timeout_err, 1'b1);
      host_open(8'h60);
      check_int("tmo_clear_av", int'({timeout_err, reg_addrvalid}), 1);
`else
      check_int("no_tmo_flag_av", int'({timeout_err, reg_addrvalid}), 1);
`endif
      host_close();
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_read_single();
      test_burst_write();
      test_read_burst();
      test_addr_change();
      test_protocol_violation();
      test_cen_high_ignore();
      test_wrap();
      test_reset_mid_burst();
      test_timeout();
      wait_cycles(4);
      check_int("wr_queue_drained", wr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
